bcd_sub16_seq: RTL and testbench

Digit-serial 4-digit (16-bit packed BCD) subtractor with borrow-in and borrow-out. It computes a − b − bin one decimal digit per clock, least-significant digit first. It is the subtract-direction companion to the combinational 4-digit BCD adder, and sits in the same decimal arithmetic datapath. Operands enter and results leave through valid/ready handshakes, so the block can sit between registered pipeline stages.

---
 rtl/bcd_sub16_seq.sv | 135 +++++++++++++
 tb/tb_bcd_sub16_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_sub16_seq.sv
// Digit-serial 4-digit packed-BCD subtractor: a - b - bin, one digit per clock, LSD first.
// Operands and result move through valid/ready handshakes; no overlap between operations.
module bcd_sub16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        invalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  idx_q, idx_d;
  logic        borrow_q, borrow_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;
  logic        invalid_q, invalid_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  a_dig, b_dig;
  logic [4:0]  t_raw, t_adj;
  logic [3:0]  d_dig;
  logic        d_borrow;
  logic        cap_invalid;

  // Any of the eight incoming digits above 9 flags the whole operation.
  always_comb begin
    cap_invalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] > 4'd9) cap_invalid = 1'b1;
      if (b[4*i +: 4] > 4'd9) cap_invalid = 1'b1;
    end
  end

  // Single digit step; the 5-bit result spans -16..15 so bit 4 is the sign.
  always_comb begin
    a_dig    = a_q[{idx_q, 2'b00} +: 4];
    b_dig    = b_q[{idx_q, 2'b00} +: 4];
    t_raw    = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_q};
    t_adj    = t_raw + 5'd10;
    d_borrow = t_raw[4];
    d_dig    = d_borrow ? t_adj[3:0] : t_raw[3:0];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    invalid_d   = invalid_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          idx_d     = 2'd0;
          borrow_d  = bin;
          invalid_d = cap_invalid;
          state_d   = CALC;
        end
      end
      CALC: begin
        diff_d[{idx_q, 2'b00} +: 4] = d_dig;
        borrow_d = d_borrow;
        if (idx_q == 2'd3) begin
          bout_d      = d_borrow;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      idx_q       <= 2'd0;
      borrow_q    <= 1'b0;
      diff_q      <= 16'h0000;
      bout_q      <= 1'b0;
      invalid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      invalid_q   <= invalid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_sub16_seq.sv
// Directed and small random checks of bcd_sub16_seq; inputs driven and outputs sampled on falling edges.
module tb_bcd_sub16_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  bcd_sub16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // One full operation: accept, check 4-cycle latency, optional stall, check result, handshake.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed, input logic eb,
                        input logic ei, input bit cd, input int stall);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      chk({tag, ".busy"}, in_ready, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 4);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, out_valid, 1);
    end
    if (cd) chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, bout, eb);
    chk({tag, ".invalid"}, invalid, ei);
    chk({tag, ".in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_post"}, out_valid, 0);
    chk({tag, ".in_ready_post"}, in_ready, 1);
    if (cd) chk({tag, ".diff_hold"}, diff, ed);
  endtask

  initial begin
    logic [15:0] ra, rb, rd;
    logic        rbi, reb;
    int          r, n;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.diff", diff, 16'h0000);
    chk("rst.bout", bout, 0);
    chk("rst.invalid", invalid, 0);
    chk("rst.in_ready", in_ready, 1);
    rst = 1'b0;

    run_op("basic",    16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b1, 0);
    run_op("wrap",     16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1, 0);
    run_op("eq_bin",   16'h1234, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1, 0);
    run_op("max_bin",  16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b1, 0);

    // Backpressure: result held, new operands ignored while stalled.
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp.latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      a = 16'h9000 + 16'(i); b = 16'h0001; bin = 1'b1; in_valid = i[0];
      @(negedge clk);
      chk("bp.out_valid", out_valid, 1);
      chk("bp.diff", diff, 16'h0025);
      chk("bp.bout", bout, 0);
      chk("bp.in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.out_valid_post", out_valid, 0);
    chk("bp.in_ready_post", in_ready, 1);
    @(negedge clk);
    chk("bp.no_capture", in_ready, 1);
    chk("bp.diff_kept", diff, 16'h0025);

    run_op("inv",      16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    run_op("inv_clr",  16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 0);

    // Asynchronous reset in the middle of digit 2.
    @(negedge clk);
    a = 16'h3333; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.busy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.diff", diff, 16'h0000);
    chk("mid.bout", bout, 0);
    chk("mid.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 16'h0100, 16'h0099, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 0);

    // Random valid-BCD operands against a decimal reference.
    for (int k = 0; k < 300; k++) begin
      ra  = int2bcd($urandom_range(9999));
      rb  = int2bcd($urandom_range(9999));
      rbi = 1'($urandom_range(1));
      r   = bcd2int(ra) - bcd2int(rb) - int'(rbi);
      reb = (r < 0);
      if (r < 0) r += 10000;
      rd  = int2bcd(r);
      run_op("rand", ra, rb, rbi, rd, reb, 1'b0, 1'b1, $urandom_range(3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
